shift_pattern_decoder: RTL and testbench

Inverse of `bit_shift_module`: it takes an 8-bit shifted word plus the shift amount that produced it, and recovers the original 5-bit `num_of_ones` payload. The word is right-shifted one position per clock, so the design uses an FSM with a down-counter. The block flags an error when the word cannot have come from a legal 5-bit payload at that shift. It sits on the receive side of the adder-project datapath, between the word source and the payload consumer, with valid/ready handshakes on both sides.

---
 rtl/shift_pattern_decoder.sv | 107 ++++++++++
 tb/tb_shift_pattern_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shift_pattern_decoder.sv
// shift_pattern_decoder
// Recovers the payload from a word that was left-shifted by k positions on
// the transmit side. The word is walked right one bit per clock under a
// down-counter; any set bit shifted out, or left above the payload field,
// marks the word as an illegal encoding for that shift.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new word; in_ready high
// SHIFT | shifting right one bit per clock, cnt counts remaining shifts
// DONE  | payload and err presented with out_valid until out_ready
module shift_pattern_decoder #(
  parameter int PAYLOAD_W = 5,
  parameter int SHIFT_W   = 2,
  localparam int DATA_W   = PAYLOAD_W + (1 << SHIFT_W) - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  shifted_data,
  input  logic [SHIFT_W-1:0] shift_by_n_pos,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PAYLOAD_W-1:0] num_of_ones,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [SHIFT_W-1:0] cnt;
  logic [DATA_W-1:0]  sr;
  logic               sticky;
  logic [DATA_W-1:0]  sr_next;
  logic               sticky_next;

  // Next shift-register value and error bit for one SHIFT step; DONE
  // outputs are loaded from these on the final step so they are ready
  // in the same cycle out_valid rises.
  always_comb begin
    sr_next     = sr >> 1;
    sticky_next = sticky | sr[0];
  end

  // Sequencer: accept, shift k times, then hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      sticky      <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      num_of_ones <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr       <= shifted_data;
            cnt      <= shift_by_n_pos;
            sticky   <= 1'b0;
            in_ready <= 1'b0;
            if (shift_by_n_pos == '0) begin
              // Nothing to shift: only the bits above the payload can be wrong.
              state       <= DONE;
              out_valid   <= 1'b1;
              num_of_ones <= shifted_data[PAYLOAD_W-1:0];
              err         <= |shifted_data[DATA_W-1:PAYLOAD_W];
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          sr     <= sr_next;
          sticky <= sticky_next;
          cnt    <= cnt - 1'b1;
          if (cnt == SHIFT_W'(1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            num_of_ones <= sr_next[PAYLOAD_W-1:0];
            err         <= sticky_next | (|sr_next[DATA_W-1:PAYLOAD_W]);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_pattern_decoder.sv
// Testbench for shift_pattern_decoder: transaction-level reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_shift_pattern_decoder;

  localparam int PW = 5;
  localparam int SW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] shifted_data = '0;
  logic [SW-1:0] shift_by_n_pos = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] num_of_ones;
  logic          err;

  int checks = 0;
  int failures = 0;

  // Reference model state (transaction level: waiting / counting down / holding)
  bit            m_idle = 1'b1;
  bit            m_valid = 1'b0;
  int            m_wait = 0;
  logic [PW-1:0] m_num = '0;
  logic          m_err = 1'b0;

  shift_pattern_decoder #(.PAYLOAD_W(PW), .SHIFT_W(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .shifted_data   (shifted_data),
    .shift_by_n_pos (shift_by_n_pos),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .num_of_ones    (num_of_ones),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Payload is the word divided by 2**k; any bit below k or above PW-1+k is illegal.
  function automatic void expect_of(input logic [DW-1:0] d, input int k,
                                    output logic [PW-1:0] p, output logic e);
    int v;
    v = int'(d);
    p = PW'((v >> k) & ((1 << PW) - 1));
    e = ((v & ((1 << k) - 1)) != 0) || ((v >> (PW + k)) != 0);
  endfunction

  // Model: result appears k+1 edges after accept, held until out_ready.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle  = 1'b1;
      m_valid = 1'b0;
      m_wait  = 0;
      m_num   = '0;
      m_err   = 1'b0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0;
        m_idle  = 1'b1;
      end
    end else if (m_idle) begin
      if (in_valid) begin
        expect_of(shifted_data, int'(shift_by_n_pos), m_num, m_err);
        m_idle  = 1'b0;
        m_wait  = int'(shift_by_n_pos);
        m_valid = (m_wait == 0);
      end
    end else begin
      m_wait = m_wait - 1;
      if (m_wait == 0) m_valid = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare the DUT against the model.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_num", 32'(num_of_ones), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
    end else begin
      chk("in_ready", 32'(in_ready), 32'(m_idle));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("num_of_ones", 32'(num_of_ones), 32'(m_num));
        chk("err", 32'(err), 32'(m_err));
      end
    end
  endtask

  // Present one word for exactly one accepting edge; returns at the negedge after accept.
  task automatic accept(input logic [DW-1:0] d, input logic [SW-1:0] k);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'(1));
    in_valid       = 1'b1;
    shifted_data   = d;
    shift_by_n_pos = k;
    tick();
    in_valid = 1'b0;
  endtask

  // Accept a word and check the first out_valid cycle against literal values.
  task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] k,
                      input logic [PW-1:0] e_num, input logic e_err, input int e_lat);
    int lat;
    accept(d, k);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("lit_num", 32'(num_of_ones), 32'(e_num));
    chk("lit_err", 32'(err), 32'(e_err));
    if (out_ready) tick();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));
    chk("post_rst_out_valid", 32'(out_valid), 32'(0));
    chk("post_rst_num", 32'(num_of_ones), 32'(0));
    chk("post_rst_err", 32'(err), 32'(0));

    out_ready = 1'b1;
    send(8'h1B, 2'd0, 5'b11011, 1'b0, 1);
    send(8'h36, 2'd1, 5'b11011, 1'b0, 2);
    send(8'h6C, 2'd2, 5'b11011, 1'b0, 3);
    send(8'hD8, 2'd3, 5'b11011, 1'b0, 4);
    send(8'h6D, 2'd2, 5'b11011, 1'b1, 3);
    send(8'h3B, 2'd0, 5'b11011, 1'b1, 1);
    send(8'h1B, 2'd3, 5'b00011, 1'b1, 4);
    send(8'hFF, 2'd1, 5'b11111, 1'b1, 2);
    send(8'h80, 2'd3, 5'b10000, 1'b0, 4);

    // Backpressure with an ignored second request
    out_ready = 1'b0;
    send(8'hD8, 2'd3, 5'b11011, 1'b0, 4);
    in_valid       = 1'b1;
    shifted_data   = 8'h1B;
    shift_by_n_pos = 2'd0;
    repeat (6) tick();
    chk("bp_out_valid", 32'(out_valid), 32'(1));
    chk("bp_in_ready", 32'(in_ready), 32'(0));
    chk("bp_num", 32'(num_of_ones), 32'(5'b11011));
    chk("bp_err", 32'(err), 32'(0));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hs_out_valid", 32'(out_valid), 32'(0));
    chk("hs_in_ready", 32'(in_ready), 32'(1));
    repeat (2) tick();

    // Reset during the second SHIFT cycle
    accept(8'hD8, 2'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    chk("midrst_num", 32'(num_of_ones), 32'(0));
    chk("midrst_err", 32'(err), 32'(0));
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("no_stale_valid", 32'(out_valid), 32'(0));
    send(8'h36, 2'd1, 5'b11011, 1'b0, 2);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
